hitmap_fiber_encoder: RTL
=========================

// Module: hitmap_fiber_encoder
// PURPOSE
//  Transmit end of the crate fiber hit link. Accepts a 38x38 cluster hit map one row at a time and
//  encodes the set bits as hit words {c, x-1, y-1} across 16 channels x 16 data cycles. Serialises
//  each frame as a sync word, the data cycles, then a trailer. Feeds the mapping_crateNN receivers.
// PARAMETERS
//  SYNC_WORD  16'hAAAA  frame sync on fiber; receiver enables on it
//  ROW_W      38        bits per map row (x = column index)
//  N_CH       16        hit channels per data cycle
//  N_CYC      16        data cycles per frame (capacity N_CH*N_CYC = 256 hits)
// PORTS
//  clk        in   1    clock
//  rst        in   1    reset; asynchronous, active-low
//  row_valid  in   1    row_bits/row_y valid
//  row_ready  out  1    row accepted on row_valid & row_ready
//  row_y      in   6    map row index (y)
//  row_bits   in   38   hit bitmap for row row_y; bit x = hit at (x,row_y)
//  row_last   in   1    final row of the frame; qualifies with the row handshake
//  fiber_id   in   10   frame/fiber id; sampled when the row_last row is accepted
//  fiber      out  16   sync / trailer word; 0 on data and idle cycles
//  fxch00..fxch15 out 16 each  hit word {3'b0, c, x[5:0]-1, y[5:0]-1}; 16'h0 when the slot is empty
//  busy       out  1    high from first row accept until GAP ends
//  overflow   out  1    high for the trailer cycle if hits were dropped this frame
// BEHAVIOUR
//  Reset (async, rst=0): FSM to IDLE; all outputs 0; hit count, held row, banks' valid bits cleared.
//  FSM: IDLE -> COLLECT on first row accept; COLLECT -> SYNC once row_last row is accepted and its
//   held bits are exhausted; SYNC(1) -> DATA(16) -> TRAIL(1) -> GAP(1) -> IDLE. Frame = 19 cycles min.
//  row_ready = (IDLE|COLLECT) & held row empty. Accepted row is held; each cycle the lowest set bit x
//   is extracted, cleared, and written as hit n (n = running count): bank n%16, address n/16.
//   Row with 0 bits costs 1 cycle; row with k>0 bits costs k cycles.
//  Hit word arithmetic: modulo-64 in 6 bits; x=0 or y=0 encodes 6'h3F (receiver +1 wraps back to 0).
//  Capacity: count saturates at 256; further hits are dropped and drop flag set; flag clears in IDLE.
//  SYNC: fiber=SYNC_WORD, fxch all 0. DATA cycle t (0..15): fiber=0, fxchNN = bank NN addr t if
//   valid, else 0. TRAIL: fiber={overflow,5'b0,fiber_id}; bit13=0 guarantees != SYNC_WORD; fxch 0.
//  GAP: all outputs 0; row_ready low; required by receiver self-reset before next SYNC.
//  All outputs are registered: fiber/fxch change one clock after the FSM state change.
//  row_valid deasserted mid-frame: COLLECT waits indefinitely; no timeout.
//  row_last on the very first row: IDLE->COLLECT->SYNC normally. Duplicate (x,y) rows are not merged.
//  Reset mid-frame: outputs go to 0 immediately; no trailer is sent; the receiver recovers on next SYNC.
// CONFIGURATION
//  HITMAP_ENC_STATS_EN defined: adds outputs stat_hits[31:0] (hits encoded) and stat_drops[31:0]
//   (hits dropped); both free-running and wrapping, updated per extracted hit, cleared by rst only.
//  Not defined: ports and counters absent; functional behaviour otherwise identical.
// STRUCTURE
//  Package hitmap_link_pkg: SYNC_WORD, ROW_W, N_CH, N_CYC, hit-word field offsets (C_BIT=12,
//   X_MSB=11, Y_MSB=5), FSM state encoding. The receivers use the same constants.
//  Sub-module hitenc_bank: 16x13-bit register file (1 write port, 1 read port, per-entry valid, bulk
//   clear); instantiated N_CH times. Top holds the FSM, the priority extractor and the output registers.
// TESTING
//  Single row y=8 bits {3} last, id=10'h155 -> SYNC AAAA; D0 fxch00=16'h1087; D1..D15 all 0;
//   TRAIL fiber=16'h0155; overflow=0.
//  All 38 rows empty, id=0 -> 38 accept cycles; SYNC; 16 all-zero data cycles; TRAIL fiber=0.
//  Row y=0 with all 38 bits set -> 38 hits; D0..D1 full and D2 ch00..05 filled; x=0 word=16'h1FFF.
//  7 full rows (266 hits) -> first 256 sent across D0..D15; overflow=1 at TRAIL; fiber[15]=1;
//   stat_drops +10 with HITMAP_ENC_STATS_EN.
//  Back-to-back frames, row_valid held high -> second SYNC no earlier than 19 cycles after first.
//  rst low during D5 -> outputs 0 in the same cycle; after release, new frame encodes cleanly.

Source files
------------

// File: rtl/hitmap_link_pkg.sv
// Shared constants for the crate fiber hit link: framing word, map geometry,
// hit-word field layout and the encoder FSM state encoding.
package hitmap_link_pkg;

    localparam logic [15:0] SYNC_WORD = 16'hAAAA;
    localparam int unsigned ROW_W     = 38;
    localparam int unsigned N_CH      = 16;
    localparam int unsigned N_CYC     = 16;
    localparam int unsigned CAP       = N_CH * N_CYC;

    localparam int unsigned C_BIT = 12;
    localparam int unsigned X_MSB = 11;
    localparam int unsigned Y_MSB = 5;
    localparam int unsigned HIT_W = C_BIT + 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_SYNC    = 3'd2;
    localparam logic [2:0] ST_DATA    = 3'd3;
    localparam logic [2:0] ST_TRAIL   = 3'd4;
    localparam logic [2:0] ST_GAP     = 3'd5;

    // Coordinates are sent minus one, modulo 64; the receiver adds one back.
    function automatic logic [HIT_W-1:0] hit_word(input logic [5:0] x, input logic [5:0] y);
        logic [HIT_W-1:0] w;
        w              = '0;
        w[C_BIT]       = 1'b1;
        w[X_MSB -: 6]  = x - 6'd1;
        w[Y_MSB -: 6]  = y - 6'd1;
        return w;
    endfunction

endpackage

// File: rtl/hitenc_bank.sv
// One hit channel's frame storage: DEPTH x W register file with a single write
// port, an asynchronous read port, per-entry valid bits and a bulk clear.
module hitenc_bank
    import hitmap_link_pkg::*;
#(
    parameter int unsigned DEPTH = N_CYC,
    parameter int unsigned W     = HIT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata,
    output logic                     rvalid
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;

    always_comb begin
        vld_d = vld_q;
        if (clr) begin
            vld_d = '0;
        end else if (we) begin
            vld_d[waddr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Payload needs no reset: every read is qualified by its valid bit.
    always_ff @(posedge clk) begin
        if (we && !clr) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata  = mem_q[raddr];
    assign rvalid = vld_q[raddr];

endmodule

// File: rtl/hitmap_fiber_encoder.sv
// Fiber hit-link transmitter: row-by-row hit map in, SYNC / 16 data cycles / TRAIL frames out.
// Optional HITMAP_ENC_STATS_EN adds free-running stat_hits / stat_drops counters.
module hitmap_fiber_encoder
    import hitmap_link_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             row_valid,
    output logic             row_ready,
    input  logic [5:0]       row_y,
    input  logic [ROW_W-1:0] row_bits,
    input  logic             row_last,
    input  logic [9:0]       fiber_id,
    output logic [15:0]      fiber,
    output logic [15:0]      fxch00,
    output logic [15:0]      fxch01,
    output logic [15:0]      fxch02,
    output logic [15:0]      fxch03,
    output logic [15:0]      fxch04,
    output logic [15:0]      fxch05,
    output logic [15:0]      fxch06,
    output logic [15:0]      fxch07,
    output logic [15:0]      fxch08,
    output logic [15:0]      fxch09,
    output logic [15:0]      fxch10,
    output logic [15:0]      fxch11,
    output logic [15:0]      fxch12,
    output logic [15:0]      fxch13,
    output logic [15:0]      fxch14,
    output logic [15:0]      fxch15,
    output logic             busy,
    output logic             overflow
`ifdef HITMAP_ENC_STATS_EN
    ,
    output logic [31:0]      stat_hits,
    output logic [31:0]      stat_drops
`endif
);

    logic [2:0]       state_q, state_d;
    logic [3:0]       cyc_q, cyc_d;
    logic [ROW_W-1:0] held_bits_q, held_bits_d;
    logic [5:0]       held_y_q, held_y_d;
    logic             held_last_q, held_last_d;
    logic             held_vld_q, held_vld_d;
    logic [9:0]       id_q, id_d;
    logic [8:0]       cnt_q, cnt_d;
    logic             drop_q, drop_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      fiber_q, fiber_d;
    logic [15:0]      fx_q [N_CH];
    logic [15:0]      fx_d [N_CH];

    logic [5:0]       lo_x;
    logic             lo_found;
    logic [ROW_W-1:0] rest_bits;
    logic             row_done;
    logic             accept;
    logic             keep_hit;
    logic             drop_hit;
    logic             bank_clr;
    logic [N_CH-1:0]  bank_we;
    logic [HIT_W-1:0] hit_wdata;
    logic [HIT_W-1:0] rd_data [N_CH];
    logic [N_CH-1:0]  rd_vld;

    always_comb begin
        lo_x     = '0;
        lo_found = 1'b0;
        // Scanning downward leaves the lowest set bit as the final winner.
        for (int unsigned i = ROW_W; i > 0; i--) begin
            if (held_bits_q[i-1]) begin
                lo_x     = 6'(i - 1);
                lo_found = 1'b1;
            end
        end
        rest_bits = held_bits_q & (held_bits_q - ROW_W'(1));
    end

    assign row_done  = held_vld_q && (rest_bits == '0);
    assign accept    = row_valid && ready_q;
    assign keep_hit  = held_vld_q && lo_found && (cnt_q < 9'(CAP));
    assign drop_hit  = held_vld_q && lo_found && !(cnt_q < 9'(CAP));
    assign bank_clr  = (state_q == ST_IDLE);
    assign hit_wdata = hit_word(lo_x, held_y_q);

    always_comb begin
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            bank_we[ch] = keep_hit && (cnt_q[3:0] == 4'(ch));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_bank
        hitenc_bank #(
            .DEPTH (N_CYC),
            .W     (HIT_W)
        ) u_bank (
            .clk    (clk),
            .rst_n  (rst),
            .clr    (bank_clr),
            .we     (bank_we[g]),
            .waddr  (cnt_q[7:4]),
            .wdata  (hit_wdata),
            .raddr  (cyc_q),
            .rdata  (rd_data[g]),
            .rvalid (rd_vld[g])
        );
    end

    always_comb begin
        held_bits_d = held_bits_q;
        held_y_d    = held_y_q;
        held_last_d = held_last_q;
        held_vld_d  = held_vld_q;
        id_d        = id_q;
        if (held_vld_q) begin
            held_bits_d = rest_bits;
            if (row_done) begin
                held_vld_d = 1'b0;
            end
        end
        if (accept) begin
            held_vld_d  = 1'b1;
            held_bits_d = row_bits;
            held_y_d    = row_y;
            held_last_d = row_last;
            if (row_last) begin
                id_d = fiber_id;
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        drop_d = drop_q;
        if (state_q == ST_IDLE) begin
            cnt_d  = '0;
            drop_d = 1'b0;
        end
        if (keep_hit) begin
            cnt_d = cnt_q + 9'd1;
        end
        if (drop_hit) begin
            drop_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (held_last_q && row_done) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                state_d = ST_DATA;
                cyc_d   = '0;
            end
            ST_DATA: begin
                cyc_d = cyc_q + 4'd1;
                if (cyc_q == 4'(N_CYC - 1)) begin
                    state_d = ST_TRAIL;
                end
            end
            ST_TRAIL: state_d = ST_GAP;
            ST_GAP:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Handshake and busy are registered from next-state so they read 0 under reset.
    always_comb begin
        ready_d = ((state_d == ST_IDLE) || (state_d == ST_COLLECT)) && !held_vld_d;
        busy_d  = (state_d != ST_IDLE);
        fiber_d = '0;
        ovf_d   = 1'b0;
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            fx_d[ch] = '0;
        end
        case (state_q)
            ST_SYNC: fiber_d = SYNC_WORD;
            ST_DATA: begin
                for (int unsigned ch = 0; ch < N_CH; ch++) begin
                    fx_d[ch] = rd_vld[ch] ? {3'b000, rd_data[ch]} : '0;
                end
            end
            ST_TRAIL: begin
                fiber_d = {drop_q, 5'b00000, id_q};
                ovf_d   = drop_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            held_bits_q <= '0;
            held_y_q    <= '0;
            held_last_q <= 1'b0;
            held_vld_q  <= 1'b0;
            id_q        <= '0;
            cnt_q       <= '0;
            drop_q      <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            fiber_q     <= '0;
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                fx_q[ch] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            held_bits_q <= held_bits_d;
            held_y_q    <= held_y_d;
            held_last_q <= held_last_d;
            held_vld_q  <= held_vld_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
            fiber_q     <= fiber_d;
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                fx_q[ch] <= fx_d[ch];
            end
        end
    end

`ifdef HITMAP_ENC_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_drops_q, stat_drops_d;

    always_comb begin
        stat_hits_d  = stat_hits_q + (keep_hit ? 32'd1 : 32'd0);
        stat_drops_d = stat_drops_q + (drop_hit ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_hits_q  <= '0;
            stat_drops_q <= '0;
        end else begin
            stat_hits_q  <= stat_hits_d;
            stat_drops_q <= stat_drops_d;
        end
    end

    assign stat_hits  = stat_hits_q;
    assign stat_drops = stat_drops_q;
`endif

    assign row_ready = ready_q;
    assign busy      = busy_q;
    assign overflow  = ovf_q;
    assign fiber     = fiber_q;
    assign fxch00    = fx_q[0];
    assign fxch01    = fx_q[1];
    assign fxch02    = fx_q[2];
    assign fxch03    = fx_q[3];
    assign fxch04    = fx_q[4];
    assign fxch05    = fx_q[5];
    assign fxch06    = fx_q[6];
    assign fxch07    = fx_q[7];
    assign fxch08    = fx_q[8];
    assign fxch09    = fx_q[9];
    assign fxch10    = fx_q[10];
    assign fxch11    = fx_q[11];
    assign fxch12    = fx_q[12];
    assign fxch13    = fx_q[13];
    assign fxch14    = fx_q[14];
    assign fxch15    = fx_q[15];

endmodule
